vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Top-level transaction controller for the vending machine.
- Sequences product selection, coin accumulation, dispensing and change/refund payout.
- Sits between the front-panel goods switches, the coin acceptor and the dispense/payout actuators.
- Uses the same price map as the selection datapath: goods one-hot bit0=2, bit1=5, bit2=7, bit3=10 yuan.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles in SELECT/PAY before automatic abort (only with AUTO_TIMEOUT_EN)
PAYOUT_GAP, 4, cycles between successive 1-yuan coin_out pulses (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
goods  in  4  one-hot product switches
confirm  in  1  single-cycle pulse, accept current selection
coin  in  3  single-cycle one-hot coin pulse: bit0=1, bit1=5, bit2=10 yuan
cancel  in  1  single-cycle pulse, abort transaction
state  out  3  IDLE=0, SELECT=1, PAY=2, DISPENSE=3, PAYOUT=4
goods_sel  out  4  latched selection
price_bin  out  4  latched price, binary
paid_bin  out  5  accumulated payment, binary, 0..19
paid_bcd  out  8  BCD of paid_bin, {tens,units}
remain_bin  out  5  yuan still owed to customer in PAYOUT
dispense  out  1  one-cycle pulse, release product
coin_out  out  1  one-cycle pulse, eject one 1-yuan coin
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - All registers 0: goods_sel, price_bin, paid_bin, remain_bin, gap and timeout counters.
  - dispense=coin_out=0.
  - Reset mid-PAYOUT abandons the payout; owed coins are lost.
- "Valid goods" means goods has exactly one bit set; 0 or multi-hot is invalid.
- IDLE:
  - Valid goods: latch goods_sel and price at the edge, go to SELECT.
  - Otherwise stay. coin, confirm and cancel are ignored.
- SELECT:
  - goods changes to a different valid value: relatch, stay.
  - goods == 0: clear goods_sel and price, go to IDLE.
  - Multi-hot goods: hold the previous latch.
  - confirm: go to PAY.
  - cancel: clear goods_sel and price, go to IDLE. cancel has priority over confirm.
- PAY:
  - A valid coin adds its value to paid_bin.
  - Multi-hot or zero coin adds nothing.
  - If paid_bin + coin >= price_bin, go to DISPENSE at the same edge.
  - goods changes are ignored.
  - cancel with paid_bin == 0 (after including a same-cycle coin): go to IDLE.
  - cancel with paid_bin > 0: remain_bin <= paid_bin (including any same-cycle coin), paid_bin <= 0, go to PAYOUT.
  - Cancel overrides the DISPENSE transition when both occur in the same cycle.
- DISPENSE (exactly 1 cycle):
  - dispense=1.
  - remain_bin <= paid_bin - price_bin; paid_bin <= 0.
  - goods_sel and price_bin are cleared.
  - Next state: PAYOUT if the change is > 0, else IDLE.
- PAYOUT:
  - Gap counter starts at 0 on entry.
  - coin_out=1 in a cycle where gap==0 and remain_bin>0; remain_bin decrements at that edge.
  - gap counts 0..PAYOUT_GAP-1 and wraps.
  - When remain_bin==0, go to IDLE.
  - All inputs are ignored.
  - First coin_out is in the first PAYOUT cycle. N yuan takes (N-1)*PAYOUT_GAP+1 cycles of pulses.
- Arithmetic:
  - paid_bin max = 9+10 = 19, fits 5 bits; no wrap is possible.
  - paid_bcd is combinational from paid_bin: units = paid mod 10, tens = paid/10.
- Output timing:
  - All outputs are registered except paid_bcd and busy (combinational from registers).
  - Latency from input pulse to state change: 1 clock.

Optional Feature:
AUTO_TIMEOUT_EN
- Defined:
  - A timeout counter runs in SELECT and PAY.
  - It clears on state entry, on any valid coin, on any goods change, and on confirm.
  - When it reaches TIMEOUT_CYCLES-1, it acts exactly as a cancel pulse that cycle.
- Undefined:
  - No counter; TIMEOUT_CYCLES is unused.
  - The machine waits indefinitely in SELECT/PAY.

Test Plan:
- goods=0100, confirm, coins 5 then 1 then 1 -> DISPENSE after the third coin, dispense pulse 1 cycle, no coin_out, back to IDLE; paid_bcd reads 05, 06, 07 along the way.
- goods=0001 (2 yuan), confirm, coin 10 -> dispense, then PAYOUT remain_bin=8, exactly 8 coin_out pulses spaced PAYOUT_GAP=4 cycles, then IDLE.
- goods=1000, confirm, coin 5, cancel -> no dispense, 5 coin_out pulses, paid_bin=0; cancel with no coins inserted -> direct IDLE, zero pulses.
- In PAY with price 7 and paid 5, drive coin=101 (invalid) -> paid stays 5; then coin 5 together with cancel -> refund of 10 coins, no dispense.
- In SELECT, goods 0001 then 0010 then 0110 -> price_bin 2, then 5, then held at 5; goods 0000 -> IDLE with cleared latch.
- With AUTO_TIMEOUT_EN and TIMEOUT_CYCLES=16: confirm, coin 1, then 16 idle cycles -> PAYOUT with 1 coin_out. Also assert rst low mid-PAYOUT -> all outputs 0 immediately, state=IDLE.

Source files
------------

// File: rtl/vend_sequencer_if.sv
// Vending sequencer port bundle: panel/coin inputs and actuator/status outputs.
// Latency: none, wires only. Backpressure: none, pulse-driven signals.
// master drives the panel and coin inputs; slave is the sequencer.
interface vend_sequencer_if;
    logic [3:0] goods;
    logic       confirm;
    logic [2:0] coin;
    logic       cancel;
    logic [2:0] state;
    logic [3:0] goods_sel;
    logic [3:0] price_bin;
    logic [4:0] paid_bin;
    logic [7:0] paid_bcd;
    logic [4:0] remain_bin;
    logic       dispense;
    logic       coin_out;
    logic       busy;

    modport master (
        output goods, confirm, coin, cancel,
        input  state, goods_sel, price_bin, paid_bin, paid_bcd, remain_bin,
        input  dispense, coin_out, busy
    );

    modport slave (
        input  goods, confirm, coin, cancel,
        output state, goods_sel, price_bin, paid_bin, paid_bcd, remain_bin,
        output dispense, coin_out, busy
    );
endinterface

// File: rtl/vend_sequencer.sv
// Vending transaction controller: select, pay, dispense, then pay out change/refund.
// Latency: 1 clock from input pulse to state/output change. Backpressure: none, inputs are pulses.
// Optional AUTO_TIMEOUT_EN: idle SELECT/PAY for TIMEOUT_CYCLES acts as a cancel.
module vend_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int PAYOUT_GAP     = 4
) (
    input  logic            clk,
    input  logic            rst,
    vend_sequencer_if.slave bus
);
    localparam int GAP_W = $clog2(PAYOUT_GAP);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PAY      = 3'd2,
        DISPENSE = 3'd3,
        PAYOUT   = 3'd4
    } state_t;

    state_t           st;
    logic [3:0]       goods_sel_r;
    logic [3:0]       price_r;
    logic [4:0]       paid_r;
    logic [4:0]       remain_r;
    logic             dispense_r;
    logic             coin_out_r;
    logic [GAP_W-1:0] gap;

    function automatic logic [3:0] price_of(input logic [3:0] g);
        case (g)
            4'b0001: price_of = 4'd2;
            4'b0010: price_of = 4'd5;
            4'b0100: price_of = 4'd7;
            4'b1000: price_of = 4'd10;
            default: price_of = 4'd0;
        endcase
    endfunction

    function automatic logic [4:0] coin_value(input logic [2:0] c);
        case (c)
            3'b001:  coin_value = 5'd1;
            3'b010:  coin_value = 5'd5;
            3'b100:  coin_value = 5'd10;
            default: coin_value = 5'd0;
        endcase
    endfunction

    logic             goods_ok;
    logic [4:0]       coin_val;
    logic [4:0]       pay_sum;
    logic [4:0]       change;
    logic             timeout_hit;
    logic             abort;
    logic             payout_pulse;
    logic [4:0]       remain_next;
    logic [GAP_W-1:0] gap_next;

    assign goods_ok     = $onehot(bus.goods);
    assign coin_val     = coin_value(bus.coin);
    // paid < price <= 10 while in PAY, so the sum tops out at 19 and never wraps
    assign pay_sum      = paid_r + coin_val;
    assign change       = paid_r - {1'b0, price_r};
    assign abort        = bus.cancel | timeout_hit;
    assign payout_pulse = (gap == '0) && (remain_r != 5'd0);
    assign remain_next  = remain_r - {4'd0, payout_pulse};
    assign gap_next     = (gap == GAP_W'(PAYOUT_GAP - 1)) ? '0 : gap + 1'b1;

`ifdef AUTO_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic [3:0]      goods_prev;
    logic            waiting;
    logic            activity;

    assign waiting     = (st == SELECT) || (st == PAY);
    assign activity    = bus.confirm || (coin_val != 5'd0) || (bus.goods != goods_prev);
    assign timeout_hit = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // held at zero outside SELECT/PAY, so every entry starts a fresh count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt     <= '0;
            goods_prev <= 4'd0;
        end else begin
            goods_prev <= bus.goods;
            if (!waiting || activity || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // no inactivity timer in this build; the parameter only keeps the port list stable
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= IDLE;
            goods_sel_r <= 4'd0;
            price_r     <= 4'd0;
            paid_r      <= 5'd0;
            remain_r    <= 5'd0;
            dispense_r  <= 1'b0;
            coin_out_r  <= 1'b0;
            gap         <= '0;
        end else begin
            dispense_r <= 1'b0;
            coin_out_r <= 1'b0;
            case (st)
                IDLE: begin
                    if (goods_ok) begin
                        goods_sel_r <= bus.goods;
                        price_r     <= price_of(bus.goods);
                        st          <= SELECT;
                    end
                end
                SELECT: begin
                    if (abort || (bus.goods == 4'd0)) begin
                        goods_sel_r <= 4'd0;
                        price_r     <= 4'd0;
                        st          <= IDLE;
                    end else begin
                        if (goods_ok) begin
                            goods_sel_r <= bus.goods;
                            price_r     <= price_of(bus.goods);
                        end
                        if (bus.confirm)
                            st <= PAY;
                    end
                end
                PAY: begin
                    if (abort) begin
                        goods_sel_r <= 4'd0;
                        price_r     <= 4'd0;
                        paid_r      <= 5'd0;
                        if (pay_sum == 5'd0) begin
                            st <= IDLE;
                        end else begin
                            remain_r   <= pay_sum;
                            gap        <= '0;
                            coin_out_r <= 1'b1;
                            st         <= PAYOUT;
                        end
                    end else if (pay_sum >= {1'b0, price_r}) begin
                        paid_r     <= pay_sum;
                        dispense_r <= 1'b1;
                        st         <= DISPENSE;
                    end else begin
                        paid_r <= pay_sum;
                    end
                end
                DISPENSE: begin
                    remain_r    <= change;
                    paid_r      <= 5'd0;
                    goods_sel_r <= 4'd0;
                    price_r     <= 4'd0;
                    gap         <= '0;
                    if (change != 5'd0) begin
                        coin_out_r <= 1'b1;
                        st         <= PAYOUT;
                    end else begin
                        st <= IDLE;
                    end
                end
                PAYOUT: begin
                    if (remain_r == 5'd0) begin
                        st <= IDLE;
                    end else begin
                        remain_r   <= remain_next;
                        gap        <= gap_next;
                        // coin_out is registered, so it is decided one cycle ahead
                        coin_out_r <= (gap_next == '0) && (remain_next != 5'd0);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    logic [3:0] bcd_tens;
    logic [4:0] bcd_units;

    always_comb begin
        bcd_tens  = 4'd0;
        bcd_units = paid_r;
        if (paid_r >= 5'd10) begin
            bcd_tens  = 4'd1;
            bcd_units = paid_r - 5'd10;
        end
    end

    assign bus.state      = st;
    assign bus.goods_sel  = goods_sel_r;
    assign bus.price_bin  = price_r;
    assign bus.paid_bin   = paid_r;
    assign bus.paid_bcd   = {bcd_tens, bcd_units[3:0]};
    assign bus.remain_bin = remain_r;
    assign bus.dispense   = dispense_r;
    assign bus.coin_out   = coin_out_r;
    assign bus.busy       = (st != IDLE);
endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized transaction bench for vend_sequencer against a transaction-level price/coin model.
module tb_vend_sequencer;
    localparam int GAP = 4;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vend_sequencer_if bus ();

    vend_sequencer #(.TIMEOUT_CYCLES(TO), .PAYOUT_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int n_disp = 0;
    int pulse_cyc[$];
    int payout_start = -1;
    logic [2:0] prev_state = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.coin_out) pulse_cyc.push_back(cyc);
        if (bus.dispense) n_disp++;
        if (bus.state == 3'd4 && prev_state != 3'd4) payout_start = cyc;
        prev_state = bus.state;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int price_of(input int g);
        case (g)
            0: return 2;
            1: return 5;
            2: return 7;
            default: return 10;
        endcase
    endfunction

    function automatic int coin_val(input logic [2:0] c);
        if (c == 3'b001) return 1;
        if (c == 3'b010) return 5;
        if (c == 3'b100) return 10;
        return 0;
    endfunction

    function automatic int bcd(input int p);
        return ((p / 10) << 4) | (p % 10);
    endfunction

    logic [2:0] cq[16];
    int ncoin;
    int cancel_at;

    task automatic gen_coins(input int price);
        int p;
        logic [2:0] c;
        p = 0;
        ncoin = 0;
        cancel_at = -1;
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 5))
                0: c = 3'b001;
                1: c = 3'b010;
                2: c = 3'b100;
                3: c = 3'b000;
                4: c = 3'b101;
                default: c = 3'b011;
            endcase
            cq[i] = c;
            ncoin = i + 1;
            if ($urandom_range(0, 5) == 0 || i == 11) begin
                cancel_at = i;
                break;
            end
            p += coin_val(c);
            if (p >= price) break;
        end
    endtask

    task automatic run_txn(input int g, input string name);
        int price, paid, pbase, dbase, exp_pulses, exp_disp, exp_state, waited, npul;
        bit done;
        price = price_of(g);
        pbase = pulse_cyc.size();
        dbase = n_disp;
        bus.goods = 4'(1 << g);
        step();
        check({name, "/sel_state"}, bus.state, 1);
        check({name, "/price"}, bus.price_bin, price);
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
        check({name, "/pay_state"}, bus.state, 2);
        paid = 0; done = 0; exp_pulses = 0; exp_disp = 0; exp_state = 2;
        for (int i = 0; i < ncoin && !done; i++) begin
            bus.coin   = cq[i];
            bus.cancel = (i == cancel_at);
            bus.goods  = 4'($urandom_range(0, 15));
            step();
            bus.coin   = 3'b000;
            bus.cancel = 1'b0;
            paid += coin_val(cq[i]);
            if (i == cancel_at) begin
                done = 1;
                exp_pulses = paid;
                exp_state = (paid == 0) ? 0 : 4;
            end else if (paid >= price) begin
                done = 1;
                exp_disp = 1;
                exp_pulses = paid - price;
                exp_state = 3;
            end else begin
                check({name, "/paid"}, bus.paid_bin, paid);
                check({name, "/paid_bcd"}, bus.paid_bcd, bcd(paid));
            end
        end
        bus.goods = 4'd0;
        check({name, "/end_state"}, bus.state, exp_state);
        if (exp_state == 3) begin
            check({name, "/dispense"}, bus.dispense, 1);
            check({name, "/disp_bcd"}, bus.paid_bcd, bcd(paid));
        end
        if (exp_state == 4) begin
            check({name, "/refund_remain"}, bus.remain_bin, exp_pulses);
            check({name, "/refund_paid"}, bus.paid_bin, 0);
        end
        waited = 0;
        while (bus.busy && waited < 200) begin
            step();
            waited++;
        end
        check({name, "/idle_reached"}, bus.busy, 0);
        check({name, "/dispense_count"}, n_disp - dbase, exp_disp);
        npul = pulse_cyc.size() - pbase;
        check({name, "/coin_out_count"}, npul, exp_pulses);
        for (int k = 1; k < npul; k++)
            check({name, "/coin_gap"}, pulse_cyc[pbase + k] - pulse_cyc[pbase + k - 1], GAP);
        if (npul > 0)
            check({name, "/first_coin"}, pulse_cyc[pbase], payout_start);
        check({name, "/remain_end"}, bus.remain_bin, 0);
        check({name, "/paid_end"}, bus.paid_bin, 0);
        check({name, "/sel_end"}, bus.goods_sel, 0);
        check({name, "/price_end"}, bus.price_bin, 0);
    endtask

    initial begin
        int g;
        bus.goods = 4'd0; bus.confirm = 1'b0; bus.coin = 3'd0; bus.cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/state", bus.state, 0);
        check("rst/busy", bus.busy, 0);
        check("rst/goods_sel", bus.goods_sel, 0);
        check("rst/price", bus.price_bin, 0);
        check("rst/paid", bus.paid_bin, 0);
        check("rst/bcd", bus.paid_bcd, 0);
        check("rst/remain", bus.remain_bin, 0);
        check("rst/dispense", bus.dispense, 0);
        check("rst/coin_out", bus.coin_out, 0);
        rst = 1'b1;
        step();

        // selection latching and release
        bus.goods = 4'b0001; step();
        check("sel/price2", bus.price_bin, 2);
        bus.goods = 4'b0010; step();
        check("sel/price5", bus.price_bin, 5);
        check("sel/sel5", bus.goods_sel, 2);
        bus.goods = 4'b0110; step();
        check("sel/multihot_price", bus.price_bin, 5);
        check("sel/multihot_sel", bus.goods_sel, 2);
        bus.goods = 4'b0000; step();
        check("sel/zero_state", bus.state, 0);
        check("sel/zero_sel", bus.goods_sel, 0);
        check("sel/zero_price", bus.price_bin, 0);
        bus.goods = 4'b1000; step();
        bus.confirm = 1'b1; bus.cancel = 1'b1; step();
        bus.confirm = 1'b0; bus.cancel = 1'b0; bus.goods = 4'b0000;
        check("sel/cancel_prio", bus.state, 0);
        bus.coin = 3'b100; bus.confirm = 1'b1; step();
        bus.coin = 3'b000; bus.confirm = 1'b0;
        check("idle/ignore_state", bus.state, 0);
        check("idle/ignore_paid", bus.paid_bin, 0);

        cq[0] = 3'b010; cq[1] = 3'b001; cq[2] = 3'b001; ncoin = 3; cancel_at = -1;
        run_txn(2, "exact7");
        cq[0] = 3'b100; ncoin = 1; cancel_at = -1;
        run_txn(0, "change8");
        cq[0] = 3'b010; cq[1] = 3'b000; ncoin = 2; cancel_at = 1;
        run_txn(3, "refund5");
        cq[0] = 3'b000; ncoin = 1; cancel_at = 0;
        run_txn(3, "cancel0");
        cq[0] = 3'b010; cq[1] = 3'b101; cq[2] = 3'b010; ncoin = 3; cancel_at = 2;
        run_txn(2, "coin_cancel10");

        // asynchronous reset in the middle of a payout
        bus.goods = 4'b0001; step();
        bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
        bus.coin = 3'b100; step(); bus.coin = 3'b000; bus.goods = 4'b0000;
        repeat (4) step();
        check("midrst/pre_state", bus.state, 4);
        rst = 1'b0;
        #1;
        check("midrst/state", bus.state, 0);
        check("midrst/remain", bus.remain_bin, 0);
        check("midrst/coin_out", bus.coin_out, 0);
        check("midrst/busy", bus.busy, 0);
        check("midrst/paid", bus.paid_bin, 0);
        step(); step();
        rst = 1'b1;
        step();
        check("midrst/after", bus.state, 0);

`ifdef AUTO_TIMEOUT_EN
        bus.goods = 4'b0100; step();
        bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
        bus.coin = 3'b001; bus.goods = 4'b0000; step(); bus.coin = 3'b000;
        repeat (15) step();
        check("timeout/still_pay", bus.state, 2);
        step();
        check("timeout/payout", bus.state, 4);
        check("timeout/remain", bus.remain_bin, 1);
        check("timeout/coin_out", bus.coin_out, 1);
        repeat (4) step();
        check("timeout/idle", bus.state, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            g = $urandom_range(0, 3);
            gen_coins(price_of(g));
            run_txn(g, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
